// File: rtl/general_counter_pkg.sv
// Shared constants and helpers for the general counter family.
// Default geometry plus the effective-modulus rule used by every digit stage.
package general_counter_pkg;

  localparam int DEF_STAGES = 4;
  localparam int DEF_WIDTH  = 4;
  localparam int DEF_MOD    = 10;

  // A raw modulus of 0 or 1 both mean "single-state digit".
  function automatic logic [31:0] eff_mod(input logic [31:0] m);
    return (m < 32'd2) ? 32'd1 : m;
  endfunction

endpackage

// File: rtl/modulo_stage.sv
// One digit of the cascaded counter: programmable modulus, up/down step,
// clamped parallel load, and a terminal flag for the carry chain.
module modulo_stage
  import general_counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] mod,
  input  logic             step,
  input  logic             up,
  output logic [WIDTH-1:0] value,
  output logic             term
);

  logic [WIDTH-1:0] top_val;
  logic [WIDTH-1:0] next_value;

  assign top_val = WIDTH'(eff_mod(32'(mod)) - 32'd1);

  // Using >= when counting up lets a value stranded above a shrunk modulus wrap out.
  assign term = up ? (value >= top_val) : (value == '0);

  always_comb begin
    next_value = value;
    if (load) begin
      next_value = (load_val > top_val) ? top_val : load_val;
    end else if (step) begin
      if (up) begin
        next_value = term ? '0 : value + WIDTH'(1);
      end else begin
        next_value = ((value == '0) || (value > top_val)) ? top_val : value - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) value <= '0;
    else     value <= next_value;
  end

endmodule

// File: rtl/cascaded_modulo_counter.sv
// Mixed-radix counter built from STAGES modulo_stage digits with a ripple
// carry chain, combinational carry-out and a registered full-wrap pulse.
module cascaded_modulo_counter
  import general_counter_pkg::*;
#(
  parameter int STAGES = DEF_STAGES,
  parameter int WIDTH  = DEF_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    up,
  input  logic                    load,
  input  logic [STAGES*WIDTH-1:0] load_val,
  input  logic [STAGES*WIDTH-1:0] mod,
  output logic [STAGES*WIDTH-1:0] q,
  output logic                    carry,
  output logic                    wrap
);

  logic [STAGES:0]   chain;
  logic [STAGES-1:0] term;

  assign chain[0] = en;

  // chain[i] is the step enable of stage i: en and every lower digit terminal.
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    modulo_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .load_val(load_val[i*WIDTH +: WIDTH]),
      .mod     (mod[i*WIDTH +: WIDTH]),
      .step    (chain[i]),
      .up      (up),
      .value   (q[i*WIDTH +: WIDTH]),
      .term    (term[i])
    );
    assign chain[i+1] = chain[i] & term[i];
  end

  assign carry = chain[STAGES];

  // A load suppresses stepping, so it can never coincide with a real wrap.
  always_ff @(posedge clk) begin
    if (rst)       wrap <= 1'b0;
    else if (load) wrap <= 1'b0;
    else           wrap <= carry;
  end

endmodule

// File: tb/tb_cascaded_modulo_counter.sv
// Scoreboard bench for a two-digit cascaded_modulo_counter: stimulus pushes
// hand-computed expectations, an independent monitor pops and compares them.
module tb_cascaded_modulo_counter;

  localparam int STAGES = 2;
  localparam int WIDTH  = 4;
  localparam int W      = STAGES * WIDTH;

  typedef struct packed {
    logic         c;
    logic [W-1:0] q;
    logic         w;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         up = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] mod = 8'hAA;
  logic [W-1:0] q;
  logic         carry;
  logic         wrap;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   issued = 0;
  int   checked = 0;

  cascaded_modulo_counter #(
    .STAGES(STAGES),
    .WIDTH (WIDTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .up      (up),
    .load    (load),
    .load_val(load_val),
    .mod     (mod),
    .q       (q),
    .carry   (carry),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic l, input logic e, input logic u,
                               input logic [W-1:0] lv, input logic [W-1:0] m,
                               input logic ec, input logic [W-1:0] eq, input logic ew);
    exp_t x;
    @(negedge clk);
    rst = r; load = l; en = e; up = u; load_val = lv; mod = m;
    x.c = ec; x.q = eq; x.w = ew;
    exp_q.push_back(x);
    issued++;
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  // Monitor: carry is sampled mid-cycle with the new inputs, q/wrap just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("carry", W'(carry), W'(e.c));
        @(posedge clk);
        #1;
        checkOutput("q", q, e.q);
        checkOutput("wrap", W'(wrap), W'(e.w));
        checked++;
      end
    end
  end

  initial begin
    logic [W-1:0] cur;
    logic [W-1:0] nxt;
    int budget;

    applyStimulus(1, 0, 0, 1, 8'h00, 8'hAA, 0, 8'h00, 0);

    // Decimal 00..99 then back to 00, carry only at 99.
    for (int k = 0; k < 100; k++) begin
      cur = {4'(k / 10), 4'(k % 10)};
      nxt = {4'(((k + 1) % 100) / 10), 4'((k + 1) % 10)};
      applyStimulus(0, 0, 1, 1, 8'h00, 8'hAA, (k == 99), nxt, (k == 99));
    end
    applyStimulus(0, 0, 0, 1, 8'h00, 8'hAA, 0, 8'h00, 0);

    // Down-count wrap with stage1 mod 6.
    applyStimulus(1, 0, 0, 0, 8'h00, 8'h6A, 0, 8'h00, 0);
    applyStimulus(0, 0, 1, 0, 8'h00, 8'h6A, 1, 8'h59, 1);
    applyStimulus(0, 0, 1, 0, 8'h00, 8'h6A, 0, 8'h58, 0);

    // Load priority and clamping.
    applyStimulus(0, 1, 1, 1, 8'h37, 8'hAA, 0, 8'h37, 0);
    applyStimulus(0, 1, 1, 1, 8'hC7, 8'hAA, 0, 8'h97, 0);
    applyStimulus(0, 1, 0, 1, 8'h99, 8'hAA, 0, 8'h99, 0);
    applyStimulus(0, 0, 0, 1, 8'h00, 8'hAA, 0, 8'h99, 0);
    applyStimulus(0, 1, 1, 1, 8'h12, 8'hAA, 1, 8'h12, 0);

    // Shrinking stage0 modulus below its current value.
    applyStimulus(0, 1, 0, 1, 8'h38, 8'hAA, 0, 8'h38, 0);
    applyStimulus(0, 0, 1, 1, 8'h00, 8'hA5, 0, 8'h40, 0);

    // Degenerate stage0 modulus 1 and 0.
    applyStimulus(0, 0, 1, 1, 8'h00, 8'hA1, 0, 8'h50, 0);
    applyStimulus(0, 0, 1, 1, 8'h00, 8'hA1, 0, 8'h60, 0);
    applyStimulus(0, 0, 1, 1, 8'h00, 8'hA0, 0, 8'h70, 0);
    applyStimulus(0, 0, 1, 1, 8'h00, 8'hA0, 0, 8'h80, 0);
    applyStimulus(0, 0, 1, 1, 8'h00, 8'hA0, 0, 8'h90, 0);
    applyStimulus(0, 0, 1, 1, 8'h00, 8'hA0, 1, 8'h00, 1);
    applyStimulus(0, 0, 1, 0, 8'h00, 8'hA0, 1, 8'h90, 1);

    // Reset beats load and en mid-operation.
    applyStimulus(0, 1, 0, 1, 8'h44, 8'hAA, 0, 8'h44, 0);
    applyStimulus(1, 1, 1, 1, 8'h77, 8'hAA, 0, 8'h00, 0);
    applyStimulus(0, 0, 1, 1, 8'h00, 8'hAA, 0, 8'h01, 0);
    applyStimulus(0, 0, 0, 1, 8'h00, 8'hAA, 0, 8'h01, 0);

    budget = 50;
    while (checked < issued && budget > 0) begin
      @(posedge clk);
      #2;
      budget--;
    end
    if (checked < issued) begin
      tests++;
      fails++;
      $display("[TB] FAIL drain: checked %0d, expected %0d", checked, issued);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
